// File: rtl/pkt_ser.sv
// Packet serializer on the FIFO read side: pops {end_flag, payload} words and
// frames each one as start, payload LSB-first, end flag and stop, paced by s_tick.
module pkt_ser #(
  parameter int DSIZE = 4,
  parameter int CSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE:0]   rdata,
  input  logic             rempty,
  output logic             r_en,
  input  logic             s_tick,
  output logic             sdata,
  output logic             sframe,
  output logic             pkt_done,
  output logic [CSIZE-1:0] pkt_cnt,
  output logic             underrun
);

  localparam int BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(DSIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_FLAG, S_STOP, S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [DSIZE-1:0]   shreg_q, shreg_d;
  logic               flag_q, flag_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic               sdata_q, sdata_d;
  logic               sframe_q, sframe_d;
  logic               pkt_done_q, pkt_done_d;
  logic [CSIZE-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic               underrun_q, underrun_d;
  logic               ld;

  // A word is accepted only on a tick; after the final word of a packet the
  // STOP tick returns to IDLE instead, which forces one idle bit between packets.
  assign ld = s_tick & ~rempty &
              ((state_q == S_IDLE) | (state_q == S_WAIT) |
               ((state_q == S_STOP) & ~flag_q));

  assign r_en = ld & ~rrst;

  always_ff @(posedge rclk) begin
    if (rrst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (s_tick) begin
      case (state_q)
        S_IDLE, S_WAIT: if (ld) state_d = S_START;
        S_START:        state_d = S_DATA;
        S_DATA:         if (bcnt_q == BCNT_LAST) state_d = S_FLAG;
        S_FLAG:         state_d = S_STOP;
        S_STOP: begin
          if (flag_q)  state_d = S_IDLE;
          else if (ld) state_d = S_START;
          else         state_d = S_WAIT;
        end
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    shreg_d    = shreg_q;
    flag_d     = flag_q;
    bcnt_d     = bcnt_q;
    sdata_d    = sdata_q;
    sframe_d   = sframe_q;
    pkt_done_d = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    underrun_d = underrun_q;
    if (ld) begin
      shreg_d  = rdata[DSIZE-1:0];
      flag_d   = rdata[DSIZE];
      sdata_d  = 1'b0;
      sframe_d = 1'b1;
    end else if (s_tick) begin
      case (state_q)
        S_START: begin
          sdata_d = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bcnt_d  = '0;
        end
        S_DATA: begin
          if (bcnt_q == BCNT_LAST) begin
            sdata_d = flag_q;
          end else begin
            sdata_d = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bcnt_d  = bcnt_q + 1'b1;
          end
        end
        S_FLAG: sdata_d = 1'b1;
        S_STOP: begin
          if (flag_q) begin
            pkt_done_d = 1'b1;
            pkt_cnt_d  = pkt_cnt_q + 1'b1;
            sframe_d   = 1'b0;
          end else begin
            // Mid-packet starvation: the line holds the stop level inside the frame.
            underrun_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      shreg_q    <= '0;
      flag_q     <= 1'b0;
      bcnt_q     <= '0;
      sdata_q    <= 1'b1;
      sframe_q   <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_cnt_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      flag_q     <= flag_d;
      bcnt_q     <= bcnt_d;
      sdata_q    <= sdata_d;
      sframe_q   <= sframe_d;
      pkt_done_q <= pkt_done_d;
      pkt_cnt_q  <= pkt_cnt_d;
      underrun_q <= underrun_d;
    end
  end

  assign sdata    = sdata_q;
  assign sframe   = sframe_q;
  assign pkt_done = pkt_done_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign underrun = underrun_q;

endmodule
